// File: rtl/flags_unit.sv
// Architectural flags register {N,Z,C,V,Q} with exception save/restore stack.
// Define FLAGS_NEST_EN for a two-entry save stack; otherwise a single entry is kept.
module flags_unit #(
    parameter int FLAGS_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic [1:0]         flags_write,
    input  logic               cond_ex,
    input  logic               sat,
    input  logic               msr_we,
    input  logic [FLAGS_W-1:0] msr_data,
    input  logic               exc_entry,
    input  logic               exc_return,
    output logic [FLAGS_W-1:0] flags,
    output logic [FLAGS_W-1:0] flags_fwd,
    output logic [FLAGS_W-1:0] spsr,
    output logic               saved,
    output logic               nest_err
);

    typedef enum logic {
        IDLE,
        SAVED
    } state_t;

    state_t             state_q, state_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic [FLAGS_W-1:0] stk0_q, stk0_d;
    logic               err_q, err_d;
`ifdef FLAGS_NEST_EN
    logic [FLAGS_W-1:0] stk1_q, stk1_d;
    logic               full_q, full_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            flags_q <= '0;
            stk0_q  <= '0;
            err_q   <= 1'b0;
`ifdef FLAGS_NEST_EN
            stk1_q  <= '0;
            full_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            stk0_q  <= stk0_d;
            err_q   <= err_d;
`ifdef FLAGS_NEST_EN
            stk1_q  <= stk1_d;
            full_q  <= full_d;
`endif
        end
    end

    // Priority chain: stall > entry > return > flush > MSR > ALU.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        stk0_d  = stk0_q;
        err_d   = 1'b0;
`ifdef FLAGS_NEST_EN
        stk1_d  = stk1_q;
        full_d  = full_q;
`endif
        if (!reset_n) begin
            state_d = IDLE;
            flags_d = '0;
            stk0_d  = '0;
`ifdef FLAGS_NEST_EN
            stk1_d  = '0;
            full_d  = 1'b0;
`endif
        end else if (stall) begin
            err_d = 1'b0;
        end else if (exc_entry) begin
            if (state_q == IDLE) begin
                stk0_d  = flags_q;
                state_d = SAVED;
            end
`ifdef FLAGS_NEST_EN
            else if (!full_q) begin
                stk1_d = flags_q;
                full_d = 1'b1;
            end
`endif
            else begin
                err_d = 1'b1;
            end
        end else if (exc_return) begin
            if (state_q == IDLE) begin
                err_d = 1'b1;
            end
`ifdef FLAGS_NEST_EN
            else if (full_q) begin
                flags_d = stk1_q;
                stk1_d  = '0;
                full_d  = 1'b0;
            end
`endif
            else begin
                flags_d = stk0_q;
                stk0_d  = '0;
                state_d = IDLE;
            end
        end else if (flush) begin
            flags_d = flags_q;
        end else if (msr_we) begin
            flags_d = msr_data;
        end else if (cond_ex) begin
            if (flags_write[1]) begin
                flags_d[4:3] = alu_flags[4:3];
            end
            if (flags_write[0]) begin
                flags_d[2:1] = alu_flags[2:1];
            end
            flags_d[0] = flags_q[0] | sat;
        end
    end

    always_comb begin
        spsr = '0;
        if (state_q == SAVED) begin
            spsr = stk0_q;
        end
`ifdef FLAGS_NEST_EN
        if (full_q) begin
            spsr = stk1_q;
        end
`endif
    end

    assign flags     = flags_q;
    assign flags_fwd = flags_d;
    assign saved     = (state_q == SAVED);
    assign nest_err  = err_q;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: directed vector table plus randomized run
// against a queue-based reference model. Honours FLAGS_NEST_EN like the design.
module tb_flags_unit;

`ifdef FLAGS_NEST_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n, stall, flush, cond_ex, sat, msr_we, exc_entry, exc_return;
    logic [4:0] alu_flags, msr_data;
    logic [1:0] flags_write;
    logic [4:0] flags, flags_fwd, spsr;
    logic       saved, nest_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flags_unit #(.FLAGS_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .alu_flags(alu_flags), .flags_write(flags_write), .cond_ex(cond_ex),
        .sat(sat), .msr_we(msr_we), .msr_data(msr_data),
        .exc_entry(exc_entry), .exc_return(exc_return),
        .flags(flags), .flags_fwd(flags_fwd), .spsr(spsr),
        .saved(saved), .nest_err(nest_err)
    );

    typedef struct {
        logic       rn, st, fl, ce, sa, mw, en, rt;
        logic [1:0] fw;
        logic [4:0] alu, md;
        logic [4:0] e_fwd, e_flags, e_spsr;
        logic       e_saved, e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // idle defaults: reset released, nothing asserted
    function automatic vec_t v(input logic [4:0] e_fwd, input logic [4:0] e_flags,
                               input logic [4:0] e_spsr, input logic e_saved, input logic e_err);
        vec_t r;
        r.rn = 1; r.st = 0; r.fl = 0; r.ce = 0; r.sa = 0; r.mw = 0; r.en = 0; r.rt = 0;
        r.fw = 2'b00; r.alu = '0; r.md = '0;
        r.e_fwd = e_fwd; r.e_flags = e_flags; r.e_spsr = e_spsr;
        r.e_saved = e_saved; r.e_err = e_err;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        reset_n = r.rn; stall = r.st; flush = r.fl; cond_ex = r.ce; sat = r.sa;
        msr_we = r.mw; exc_entry = r.en; exc_return = r.rt;
        flags_write = r.fw; alu_flags = r.alu; msr_data = r.md;
    endtask

    task automatic build_table();
        vec_t r;
        r = v(5'b00000, 5'b00000, 5'b00000, 0, 0); r.rn = 0; r.ce = 1; r.fw = 2'b11; r.alu = 5'b11111; r.en = 1; vecs.push_back(r);
        r = v(5'b10100, 5'b10100, 5'b00000, 0, 0); r.ce = 1; r.fw = 2'b11; r.alu = 5'b10100; vecs.push_back(r);
        r = v(5'b01010, 5'b01010, 5'b00000, 0, 0); r.mw = 1; r.md = 5'b01010; vecs.push_back(r);
        r = v(5'b01100, 5'b01100, 5'b00000, 0, 0); r.ce = 1; r.fw = 2'b01; r.alu = 5'b10100; vecs.push_back(r);
        r = v(5'b01100, 5'b01100, 5'b00000, 0, 0); r.ce = 0; r.fw = 2'b11; r.alu = 5'b10011; r.sa = 1; vecs.push_back(r);
        r = v(5'b01101, 5'b01101, 5'b00000, 0, 0); r.ce = 1; r.sa = 1; vecs.push_back(r);
        r = v(5'b00001, 5'b00001, 5'b00000, 0, 0); r.ce = 1; r.fw = 2'b11; r.alu = 5'b00000; vecs.push_back(r);
        r = v(5'b00001, 5'b00001, 5'b00000, 0, 0); r.fl = 1; r.ce = 1; r.sa = 1; r.fw = 2'b11; r.alu = 5'b11110; vecs.push_back(r);
        r = v(5'b00000, 5'b00000, 5'b00000, 0, 0); r.mw = 1; r.md = 5'b00000; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b00000, 0, 0); r.mw = 1; r.md = 5'b11001; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b11001, 1, 0); r.en = 1; r.ce = 1; r.fw = 2'b11; r.alu = 5'b00000; vecs.push_back(r);
        r = v(5'b00000, 5'b00000, 5'b11001, 1, 0); r.mw = 1; r.md = 5'b00000; vecs.push_back(r);
        r = v(5'b00000, 5'b00000, 5'b11001, 1, 0); r.st = 1; r.en = 1; r.mw = 1; r.md = 5'b11111; r.ce = 1; r.fw = 2'b11; r.alu = 5'b11110; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b00000, 0, 0); r.rt = 1; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b00000, 0, 1); r.rt = 1; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b00000, 0, 0); vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b11001, 1, 0); r.en = 1; vecs.push_back(r);
        r = v(5'b00110, 5'b00110, 5'b11001, 1, 0); r.mw = 1; r.md = 5'b00110; vecs.push_back(r);
`ifdef FLAGS_NEST_EN
        r = v(5'b00110, 5'b00110, 5'b00110, 1, 0); r.en = 1; r.rt = 1; vecs.push_back(r);
        r = v(5'b00110, 5'b00110, 5'b11001, 1, 0); r.rt = 1; vecs.push_back(r);
        r = v(5'b00110, 5'b00110, 5'b00110, 1, 0); r.en = 1; vecs.push_back(r);
        r = v(5'b00110, 5'b00110, 5'b00110, 1, 1); r.en = 1; vecs.push_back(r);
`else
        r = v(5'b00110, 5'b00110, 5'b11001, 1, 1); r.en = 1; r.rt = 1; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b00000, 0, 0); r.rt = 1; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b11001, 1, 0); r.en = 1; vecs.push_back(r);
        r = v(5'b11001, 5'b11001, 5'b11001, 1, 1); r.en = 1; vecs.push_back(r);
`endif
        r = v(5'b00000, 5'b00000, 5'b00000, 0, 0); r.rn = 0; r.rt = 1; r.mw = 1; r.md = 5'b10101; vecs.push_back(r);
    endtask

    // Reference model: architectural flags plus a LIFO of saved values.
    logic [4:0] m_flags;
    logic [4:0] m_stack[$];
    logic       m_err;

    task automatic model_step(input vec_t r, output logic [4:0] nxt);
        logic [4:0] f;
        logic       e;
        f = m_flags;
        e = 1'b0;
        if (!r.rn) begin
            f = 5'b0;
            m_stack.delete();
        end else if (r.st) begin
            e = 1'b0;
        end else if (r.en) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else e = 1'b1;
        end else if (r.rt) begin
            if (m_stack.size() > 0) f = m_stack.pop_back();
            else e = 1'b1;
        end else if (r.fl) begin
            f = m_flags;
        end else if (r.mw) begin
            f = r.md;
        end else if (r.ce) begin
            f = {r.fw[1] ? r.alu[4:3] : m_flags[4:3],
                 r.fw[0] ? r.alu[2:1] : m_flags[2:1],
                 m_flags[0] | r.sa};
        end
        m_flags = f;
        m_err   = e;
        nxt     = f;
    endtask

    task automatic apply_and_check(input vec_t r, input string tag);
        @(negedge clk);
        drive(r);
        #1;
        check({tag, ".fwd"}, flags_fwd, r.e_fwd);
        @(posedge clk);
        #1;
        check({tag, ".flags"}, flags, r.e_flags);
        check({tag, ".spsr"}, spsr, r.e_spsr);
        check({tag, ".saved"}, {4'b0, saved}, {4'b0, r.e_saved});
        check({tag, ".nest_err"}, {4'b0, nest_err}, {4'b0, r.e_err});
    endtask

    initial begin
        vec_t r;
        logic [4:0] nxt;
        r = v('0, '0, '0, 0, 0);
        r.rn = 0;
        drive(r);
        build_table();
        foreach (vecs[i]) apply_and_check(vecs[i], $sformatf("vec%0d", i));

        m_flags = '0;
        m_stack.delete();
        for (int unsigned n = 0; n < 3000; n++) begin
            r = v('0, '0, '0, 0, 0);
            r.rn  = ($urandom_range(99) >= 2);
            r.st  = ($urandom_range(99) < 10);
            r.en  = ($urandom_range(99) < 8);
            r.rt  = ($urandom_range(99) < 9);
            r.fl  = ($urandom_range(99) < 10);
            r.mw  = ($urandom_range(99) < 12);
            r.ce  = ($urandom_range(99) < 70);
            r.sa  = ($urandom_range(99) < 15);
            r.fw  = 2'($urandom);
            r.alu = 5'($urandom);
            r.md  = 5'($urandom);
            model_step(r, nxt);
            r.e_fwd   = nxt;
            r.e_flags = nxt;
            r.e_spsr  = (m_stack.size() > 0) ? m_stack[$] : 5'b0;
            r.e_saved = (m_stack.size() > 0);
            r.e_err   = m_err;
            apply_and_check(r, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
